shift_reg_universal: RTL and testbench
======================================

// Module: shift_reg_universal
// PURPOSE
//  - Parametrised successor to the single-bit D flip-flop: a WIDTH-bit universal shift register.
//  - Supports hold, shift right, shift left and parallel load.
//  - Counts the shifts since the last load and pulses done once WIDTH bits have been shifted.
//  - Serves as the serializer/deserializer building block for the lab datapaths.
// PARAMETERS
//  - WIDTH      8   register width in bits, >=2
//  - RESET_VAL  0   value loaded into q on reset (WIDTH bits)
// PORTS
//  - clk     in   1                 rising-edge clock
//  - reset   in   1                 reset, synchronous, active-high
//  - en      in   1                 1 = act on mode this cycle; 0 = hold everything
//  - mode    in   2                 00 hold, 01 shift right, 10 shift left, 11 parallel load
//  - sin_r   in   1                 serial input entering the MSB on a right shift
//  - sin_l   in   1                 serial input entering the LSB on a left shift
//  - d       in   WIDTH             parallel load data
//  - q       out  WIDTH             register contents
//  - sout_r  out  1                 q[0]; the bit leaving on a right shift
//  - sout_l  out  1                 q[WIDTH-1]; the bit leaving on a left shift
//  - count   out  $clog2(WIDTH+1)   shifts since the last load/reset; saturates at WIDTH
//  - done    out  1                 one-cycle pulse on the edge where count becomes WIDTH
// BEHAVIOUR
//  - All state updates on posedge clk. Nonblocking assignments only.
//  - Reset: q=RESET_VAL, count=0, done=0.
//    - Reset has priority over en and mode; reset mid-shift abandons the count.
//  - en=0 or mode=00: q and count hold; done=0.
//  - mode=01: q <= {sin_r, q[WIDTH-1:1]}.
//  - mode=10: q <= {q[WIDTH-2:0], sin_l}.
//  - mode=11: q <= d, count <= 0, done <= 0. A load always restarts the count.
//  - On a shift with count<WIDTH: count <= count+1.
//    - done <= 1 only when the new count equals WIDTH; otherwise done <= 0.
//  - On a shift with count==WIDTH: q still shifts, count stays WIDTH (no wrap-around), done <= 0.
//  - Latency: q, count and done reflect the operation one cycle after the sampling edge.
//  - sout_r and sout_l are combinational from q, with no extra register.
//  - Left and right shifts may be mixed. Each one counts as a shift.
//  - Implicit two-state counter FSM:
//    - COUNTING (count<WIDTH) goes to FULL on the WIDTH-th shift.
//    - FULL goes back to COUNTING on a load or reset.
// CONFIGURATION
//  - Macro SHIFT_REG_UNIVERSAL_ROTATE_EN.
//  - Defined: adds input `rot` (1 bit).
//    - When rot=1, a right shift enters q[0] into the MSB and a left shift enters q[WIDTH-1] into the LSB.
//    - sin_r and sin_l are ignored in that case.
//    - Counting and done are unchanged.
//  - Undefined: port rot is absent and shifts always use sin_r/sin_l.
// STRUCTURE
//  - Package shift_reg_pkg:
//    - typedef enum logic [1:0] {MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD} shift_mode_t.
//    - Function cnt_w(WIDTH) = $clog2(WIDTH+1).
//  - Sub-module ffd_en_cell: 1-bit D flip-flop with sync active-high reset, reset value and enable.
//    - Generated WIDTH times.
//    - The next-state mux per bit lives in the parent.
// TESTING
//  - Reset: reset=1 for 1 cycle with WIDTH=8 -> q=8'h00, count=0, done=0.
//  - Load: mode=11, d=8'hA5, en=1 -> q=8'hA5 after 1 edge, count=0.
//  - Right shift: 8 right shifts with sin_r=1 from 8'hA5 -> q=8'hFF.
//    - sout_r sequence 1,0,1,0,0,1,0,1.
//    - done=1 only after the 8th edge.
//  - Saturation: 9th left shift with sin_l=0 -> q=8'hFE, count stays 8, done=0.
//  - Hold and reset priority:
//    - en=0 with mode=01 for 3 cycles -> q and count unchanged.
//    - reset=1 together with mode=11 -> q=RESET_VAL.
//  - Rotate (SHIFT_REG_UNIVERSAL_ROTATE_EN): load 8'h81, rot=1, 1 left shift -> q=8'h03.
//    - After 8 rotates q=8'h81 and done pulses.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the universal shift register.
// Holds the mode encoding, the counter-state encoding and the count-width function.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } shift_mode_t;

  typedef enum logic {
    ST_COUNTING = 1'b0,
    ST_FULL     = 1'b1
  } cnt_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_reg_universal_ffd_en_cell.sv
// One-bit D flip-flop with synchronous active-high reset, reset value and enable.
// The parent instantiates one cell per register bit and owns the next-state mux.
module ffd_en_cell #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);

  logic q_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= RESET_VAL;
    end else if (en) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/shift_reg_universal.sv
// WIDTH-bit universal shift register: hold, shift right/left, parallel load, shift counter.
// Optional macro SHIFT_REG_UNIVERSAL_ROTATE_EN adds a rot input for circular shifts.
module shift_reg_universal
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [1:0]                mode,
`ifdef SHIFT_REG_UNIVERSAL_ROTATE_EN
  input  logic                      rot,
`endif
  input  logic                      sin_r,
  input  logic                      sin_l,
  input  logic [WIDTH-1:0]          d,
  output logic [WIDTH-1:0]          q,
  output logic                      sout_r,
  output logic                      sout_l,
  output logic [cnt_w(WIDTH)-1:0]   count,
  output logic                      done
);

  localparam int              CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]   FULL_CNT = CW'(WIDTH);

  shift_mode_t    mode_e;
  cnt_state_t     cnt_state;
  logic [WIDTH-1:0] q_q, q_d;
  logic           q_en;
  logic [CW-1:0]  count_q, count_d;
  logic           done_q, done_d;
  logic           shift_in_r, shift_in_l;
  logic           is_shift;

  assign mode_e = shift_mode_t'(mode);

  // The counter FSM state is fully encoded by the count itself.
  assign cnt_state = (count_q == FULL_CNT) ? ST_FULL : ST_COUNTING;

`ifdef SHIFT_REG_UNIVERSAL_ROTATE_EN
  assign shift_in_r = rot ? q_q[0]       : sin_r;
  assign shift_in_l = rot ? q_q[WIDTH-1] : sin_l;
`else
  assign shift_in_r = sin_r;
  assign shift_in_l = sin_l;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    q_d      = q_q;
    q_en     = 1'b0;
    count_d  = count_q;
    done_d   = 1'b0;
    is_shift = 1'b0;
    if (en) begin
      case (mode_e)
        MODE_SHR: begin
          q_d      = {shift_in_r, q_q[WIDTH-1:1]};
          q_en     = 1'b1;
          is_shift = 1'b1;
        end
        MODE_SHL: begin
          q_d      = {q_q[WIDTH-2:0], shift_in_l};
          q_en     = 1'b1;
          is_shift = 1'b1;
        end
        MODE_LOAD: begin
          q_d     = d;
          q_en    = 1'b1;
          count_d = '0;
        end
        default: ;
      endcase
    end
    if (is_shift && cnt_state == ST_COUNTING) begin
      count_d = count_q + 1'b1;
      done_d  = (count_d == FULL_CNT);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ffd_en_cell #(
      .RESET_VAL (RESET_VAL[i])
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .en    (q_en),
      .d     (q_d[i]),
      .q     (q_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign q      = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];
  assign count  = count_q;
  assign done   = done_q;

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed self-checking bench for shift_reg_universal with WIDTH=8, RESET_VAL=0.
// Rotate checks are built only when SHIFT_REG_UNIVERSAL_ROTATE_EN is defined.
module tb_shift_reg_universal;

  logic       clk = 1'b0;
  logic       reset, en, sin_r, sin_l;
  logic [1:0] mode;
  logic [7:0] d, q;
  logic       sout_r, sout_l, done;
  logic [3:0] count;
`ifdef SHIFT_REG_UNIVERSAL_ROTATE_EN
  logic       rot;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_reg_universal #(
    .WIDTH     (8),
    .RESET_VAL (8'h00)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .mode   (mode),
`ifdef SHIFT_REG_UNIVERSAL_ROTATE_EN
    .rot    (rot),
`endif
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .d      (d),
    .q      (q),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .count  (count),
    .done   (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [7:0] eq,
                             input logic [3:0] ec, input logic ed);
    check({tag, ".q"},     32'(q),     32'(eq));
    check({tag, ".count"}, 32'(count), 32'(ec));
    check({tag, ".done"},  32'(done),  32'(ed));
  endtask

  logic [7:0] shr_q   [8] = '{8'hD2, 8'hE9, 8'hF4, 8'hFA, 8'hFD, 8'hFE, 8'hFF, 8'hFF};
  logic       shr_out [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef SHIFT_REG_UNIVERSAL_ROTATE_EN
  logic [7:0] rot_q   [8] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
`endif

  initial begin
    reset = 1'b1; en = 1'b0; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0; d = 8'h00;
`ifdef SHIFT_REG_UNIVERSAL_ROTATE_EN
    rot = 1'b0;
`endif
    step();
    check_state("reset", 8'h00, 4'd0, 1'b0);
    reset = 1'b0;

    en = 1'b1; mode = 2'b11; d = 8'hA5;
    step();
    check_state("load_a5", 8'hA5, 4'd0, 1'b0);

    mode = 2'b01; sin_r = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("shr%0d.sout_r", i), 32'(sout_r), 32'(shr_out[i]));
      step();
      check_state($sformatf("shr%0d", i), shr_q[i], 4'(i + 1), i == 7);
    end
    check("full.sout_l", 32'(sout_l), 32'd1);

    mode = 2'b10; sin_l = 1'b0;
    step();
    check_state("sat_shl", 8'hFE, 4'd8, 1'b0);
    check("sat.sout_r", 32'(sout_r), 32'd0);

    en = 1'b0; mode = 2'b01; sin_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state($sformatf("hold%0d", i), 8'hFE, 4'd8, 1'b0);
    end

    en = 1'b1; mode = 2'b11; d = 8'h3C;
    step();
    check_state("reload", 8'h3C, 4'd0, 1'b0);
    mode = 2'b10; sin_l = 1'b1;
    step();
    check_state("mix_shl", 8'h79, 4'd1, 1'b0);
    mode = 2'b01; sin_r = 1'b0;
    step();
    check_state("mix_shr", 8'h3C, 4'd2, 1'b0);
    mode = 2'b00;
    step();
    check_state("mode_hold", 8'h3C, 4'd2, 1'b0);

    reset = 1'b1; mode = 2'b11; d = 8'h5A;
    step();
    check_state("reset_prio", 8'h00, 4'd0, 1'b0);
    reset = 1'b0;

`ifdef SHIFT_REG_UNIVERSAL_ROTATE_EN
    mode = 2'b11; d = 8'h81;
    step();
    check_state("rot_load", 8'h81, 4'd0, 1'b0);
    mode = 2'b10; rot = 1'b1; sin_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_state($sformatf("rot%0d", i), rot_q[i], 4'(i + 1), i == 7);
    end
    mode = 2'b01; sin_r = 1'b0;
    step();
    check_state("rot_shr", 8'hC0, 4'd8, 1'b0);
    rot = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
